cpu_trace_monitor: RTL and testbench

// - Parametrised, synthesisable execution monitor for the multicycle RISC-V CPU; replaces fixed-#delay $stop benches.
// - Captures one trace entry per retired instruction (pc, instr, rd writeback) into a DEPTH-entry circular buffer.
// - Counts clock cycles; raises sticky halt on cycle limit or PC breakpoint.
// - Drains the buffer through a valid/ready read port; usable in simulation and on FPGA.

---
 rtl/cpu_trace_monitor.sv | 169 ++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_monitor.sv
// Execution trace monitor: DEPTH-entry circular buffer of retired instructions, cycle counter, sticky halt.
// Latency: an entry retired at edge N is visible on rd* after edge N; rd* is driven combinationally from the head entry.
// Backpressure: the rdValid/rdReady drain is consumer-paced; a full buffer drops retires and sets overflow. Macro TRACE_MEM_EN adds memory-access fields.
module cpu_trace_monitor #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       clr,
    input  logic                       retire,
    input  logic [XLEN-1:0]            pc,
    input  logic [31:0]                instr,
    input  logic                       regWEn,
    input  logic [4:0]                 rd,
    input  logic [XLEN-1:0]            regDataIn,
    input  logic [CYCLE_W-1:0]         cycleLimit,
    input  logic                       bpEn,
    input  logic [XLEN-1:0]            bpAddr,
    input  logic                       rdReady,
`ifdef TRACE_MEM_EN
    input  logic                       memWrite,
    input  logic [XLEN-1:0]            memAddr,
    input  logic [XLEN-1:0]            memData,
    output logic                       rdMemWe,
    output logic [XLEN-1:0]            rdMemAddr,
    output logic [XLEN-1:0]            rdMemData,
`endif
    output logic                       rdValid,
    output logic [XLEN-1:0]            rdPc,
    output logic [31:0]                rdInstr,
    output logic                       rdWe,
    output logic [4:0]                 rdRd,
    output logic [XLEN-1:0]            rdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       halt,
    output logic [1:0]                 haltCause,
    output logic [CYCLE_W-1:0]         cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
`ifdef TRACE_MEM_EN
        logic            mem_we;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
`endif
    } entry_t;

    entry_t             trace_buf [DEPTH];
    entry_t             last_head;
    entry_t             head;
    entry_t             new_entry;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               pop;
    logic               capture_ok;
    logic               push;
    logic               drop;
    logic               lim_hit;
    logic               bp_hit;
    logic [CYCLE_W:0]   cycles_inc;

    always_comb begin
        new_entry          = '0;
        new_entry.pc       = pc;
        new_entry.instr    = instr;
        new_entry.we       = regWEn;
        new_entry.rd       = rd;
        new_entry.data     = regDataIn;
`ifdef TRACE_MEM_EN
        new_entry.mem_we   = memWrite;
        new_entry.mem_addr = memAddr;
        new_entry.mem_data = memData;
`endif
    end

    assign full       = (count == CW'(DEPTH));
    assign rdValid    = (count != '0);
    assign pop        = rdValid && rdReady;
    assign capture_ok = retire && !halt;
    assign push       = capture_ok && (!full || pop);
    assign drop       = capture_ok && full && !pop;

    // The limit compares against the post-increment value so halt lands on the same edge cycles reaches it.
    assign cycles_inc = {1'b0, cycles} + (CYCLE_W+1)'(1);
    assign lim_hit    = !halt && (cycleLimit != '0) && (cycles_inc == {1'b0, cycleLimit});
    assign bp_hit     = retire && bpEn && (pc == bpAddr) && !halt;

    // An empty buffer shows the most recently popped head instead of a stale slot.
    assign head      = rdValid ? trace_buf[rd_ptr] : last_head;
    assign rdPc      = head.pc;
    assign rdInstr   = head.instr;
    assign rdWe      = head.we;
    assign rdRd      = head.rd;
    assign rdData    = head.data;
`ifdef TRACE_MEM_EN
    assign rdMemWe   = head.mem_we;
    assign rdMemAddr = head.mem_addr;
    assign rdMemData = head.mem_data;
`endif

    // Storage needs no reset: slots are only observed after they have been written.
    always_ff @(posedge clk) begin
        if (rstN && !clr && push) begin
            trace_buf[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            haltCause <= 2'b00;
            cycles    <= '0;
            last_head <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            haltCause <= 2'b00;
            cycles    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_head <= trace_buf[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (!halt && !(&cycles)) begin
                cycles <= cycles + CYCLE_W'(1);
            end
            if (lim_hit || bp_hit) begin
                halt <= 1'b1;
            end
            if (lim_hit) begin
                haltCause[0] <= 1'b1;
            end
            if (bp_hit) begin
                haltCause[1] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: capture/drain order, overflow, cycle-limit and breakpoint halts, clear and async reset.
module tb_cpu_trace_monitor;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clr;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        regWEn;
    logic [4:0]  rd;
    logic [31:0] regDataIn;
    logic [15:0] cycleLimit;
    logic        bpEn;
    logic [31:0] bpAddr;
    logic        rdReady;
`ifdef TRACE_MEM_EN
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        rdMemWe;
    logic [31:0] rdMemAddr;
    logic [31:0] rdMemData;
`endif
    logic        rdValid;
    logic [31:0] rdPc;
    logic [31:0] rdInstr;
    logic        rdWe;
    logic [4:0]  rdRd;
    logic [31:0] rdData;
    logic [4:0]  count;
    logic        overflow;
    logic        halt;
    logic [1:0]  haltCause;
    logic [15:0] cycles;

    int vectors     = 0;
    int miscompares = 0;

    cpu_trace_monitor #(.XLEN(32), .DEPTH(16), .CYCLE_W(16)) dut (
        .clk(clk), .rstN(rstN), .clr(clr), .retire(retire), .pc(pc), .instr(instr),
        .regWEn(regWEn), .rd(rd), .regDataIn(regDataIn), .cycleLimit(cycleLimit),
        .bpEn(bpEn), .bpAddr(bpAddr), .rdReady(rdReady),
`ifdef TRACE_MEM_EN
        .memWrite(memWrite), .memAddr(memAddr), .memData(memData),
        .rdMemWe(rdMemWe), .rdMemAddr(rdMemAddr), .rdMemData(rdMemData),
`endif
        .rdValid(rdValid), .rdPc(rdPc), .rdInstr(rdInstr), .rdWe(rdWe), .rdRd(rdRd),
        .rdData(rdData), .count(count), .overflow(overflow), .halt(halt),
        .haltCause(haltCause), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
        retire    = 1'b1;
        pc        = p;
        instr     = 32'h0000_0013 | (32'(r) << 7);
        regWEn    = 1'b1;
        rd        = r;
        regDataIn = d;
        tick();
        retire    = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; clr = 1'b0; retire = 1'b0; pc = '0; instr = '0; regWEn = 1'b0;
        rd = '0; regDataIn = '0; cycleLimit = '0; bpEn = 1'b0; bpAddr = '0; rdReady = 1'b0;
`ifdef TRACE_MEM_EN
        memWrite = 1'b0; memAddr = '0; memData = '0;
`endif
        #12;
        check("rst_valid", rdValid, 0);
        check("rst_count", count, 0);
        check("rst_cycles", cycles, 0);
        check("rst_halt", {halt, haltCause, overflow}, 0);
        check("rst_pc", rdPc, 0);
        rstN = 1'b1;
        clr = 1'b1; tick(); clr = 1'b0;

        // three retires held, then drained in order
`ifdef TRACE_MEM_EN
        memWrite = 1'b1; memAddr = 32'h100; memData = 32'hDEAD;
`endif
        retire_one(32'h0, 5'd1, 32'd10);
`ifdef TRACE_MEM_EN
        memWrite = 1'b0; memAddr = '0; memData = '0;
`endif
        retire_one(32'h4, 5'd2, 32'd20);
        retire_one(32'h8, 5'd3, 32'd30);
        check("t1_count", count, 3);
        check("t1_valid", rdValid, 1);
        check("t1_head_pc", rdPc, 32'h0);
        check("t1_head_instr", rdInstr, 32'h0000_0093);
        check("t1_head_rd", {rdWe, rdRd}, {1'b1, 5'd1});
        check("t1_head_data", rdData, 10);
`ifdef TRACE_MEM_EN
        check("mem_we", rdMemWe, 1);
        check("mem_addr", rdMemAddr, 32'h100);
        check("mem_data", rdMemData, 32'hDEAD);
`endif
        rdReady = 1'b1;
        tick();
        check("t1_pop1_pc", rdPc, 32'h4);
        check("t1_pop1_count", count, 2);
        tick();
        check("t1_pop2_data", rdData, 30);
        check("t1_pop2_rd", rdRd, 3);
        tick();
        check("t1_empty_count", count, 0);
        check("t1_empty_valid", rdValid, 0);
        check("t1_hold_pc", rdPc, 32'h8);
        rdReady = 1'b0;

        // fill past DEPTH, then push+pop at full
        for (int i = 0; i < 18; i++) retire_one(32'h100 + 32'(4 * i), 5'd4, 32'(i));
        check("t2_count_full", count, 16);
        check("t2_overflow", overflow, 1);
        check("t2_head_pc", rdPc, 32'h100);
        retire = 1'b1; pc = 32'h200; rdReady = 1'b1;
        tick();
        retire = 1'b0; rdReady = 1'b0;
        check("t2_pushpop_count", count, 16);
        check("t2_pushpop_ovf", overflow, 1);
        check("t2_pushpop_head", rdPc, 32'h104);

        // cycle limit
        clr = 1'b1; cycleLimit = 16'd100; tick(); clr = 1'b0;
        check("t3_clr_count", count, 0);
        check("t3_clr_ovf", overflow, 0);
        check("t3_clr_cycles", cycles, 0);
        repeat (99) tick();
        check("t3_pre_halt", halt, 0);
        check("t3_pre_cycles", cycles, 99);
        tick();
        check("t3_halt", halt, 1);
        check("t3_cycles", cycles, 100);
        check("t3_cause", haltCause, 2'b01);
        retire_one(32'h300, 5'd5, 32'd5);
        repeat (4) tick();
        check("t3_frozen", cycles, 100);
        check("t3_no_capture", count, 0);

        // breakpoint; clr beats a same-edge retire
        cycleLimit = '0; clr = 1'b1; retire = 1'b1; pc = 32'h50; tick(); clr = 1'b0; retire = 1'b0;
        check("t4_clr_discards", count, 0);
        check("t4_clr_halt", halt, 0);
        bpEn = 1'b1; bpAddr = 32'h20;
        retire_one(32'h1C, 5'd6, 32'd6);
        retire_one(32'h20, 5'd7, 32'd7);
        check("t4_bp_halt", halt, 1);
        check("t4_bp_cause", haltCause, 2'b10);
        check("t4_bp_captured", count, 2);
        retire_one(32'h24, 5'd8, 32'd8);
        check("t4_ignored", count, 2);
        rdReady = 1'b1; tick(); rdReady = 1'b0;
        check("t4_drain_halted", rdPc, 32'h20);
        check("t4_drain_count", count, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t4_release", {halt, haltCause}, 0);
        check("t4_release_count", count, 0);

        // both halt causes on one edge, then async reset mid-drain
        clr = 1'b1; cycleLimit = 16'd3; bpAddr = 32'h40; tick(); clr = 1'b0;
        retire_one(32'h38, 5'd9, 32'd9);
        retire_one(32'h3C, 5'd10, 32'd10);
        retire_one(32'h40, 5'd11, 32'd11);
        check("t5_cause", haltCause, 2'b11);
        check("t5_cycles", cycles, 3);
        check("t5_count", count, 3);
        rdReady = 1'b1; tick();
        check("t5_drain", count, 2);
        #2 rstN = 1'b0;
        #1;
        check("t5_rst_valid", rdValid, 0);
        check("t5_rst_count", count, 0);
        check("t5_rst_status", {halt, haltCause, overflow}, 0);
        check("t5_rst_cycles", cycles, 0);
        check("t5_rst_fields", {rdPc, rdData}, 0);
        check("t5_rst_rd", {rdWe, rdRd, rdInstr}, 0);
        rdReady = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
